// File: rtl/aes_block_gearbox_if.sv
// Stream/block handshake bundle for aes_block_gearbox: plaintext words in, block to the core,
// result block back, ciphertext words out, plus status.
interface aes_block_gearbox_if;
    logic         pt_valid_i;
    logic [31:0]  pt_data_i;
    logic         pt_ready_o;
    logic         blk_valid_o;
    logic [127:0] blk_data_o;
    logic         blk_ready_i;
    logic         res_valid_i;
    logic [127:0] res_data_i;
    logic         res_ready_o;
    logic         ct_valid_o;
    logic [31:0]  ct_data_o;
    logic         ct_ready_i;
    logic [1:0]   word_cnt_o;
    logic         busy_o;
    logic         done_o;

    modport slave (
        input  pt_valid_i, pt_data_i, blk_ready_i, res_valid_i, res_data_i, ct_ready_i,
        output pt_ready_o, blk_valid_o, blk_data_o, res_ready_o, ct_valid_o, ct_data_o,
        output word_cnt_o, busy_o, done_o
    );

    modport master (
        output pt_valid_i, pt_data_i, blk_ready_i, res_valid_i, res_data_i, ct_ready_i,
        input  pt_ready_o, blk_valid_o, blk_data_o, res_ready_o, ct_valid_o, ct_data_o,
        input  word_cnt_o, busy_o, done_o
    );
endinterface

// File: rtl/aes_block_gearbox.sv
// 32-bit word stream <-> 128-bit AES block gearbox (FILL/ISSUE/WAIT/DRAIN).
// Optional macro AES_GEARBOX_BYTESWAP_EN byte-reverses words on ingress and egress.
module aes_block_gearbox #(
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 reset_n,
    input logic                 clear,
    aes_block_gearbox_if.slave  bus
);
    typedef enum logic [1:0] {StFill, StIssue, StWait, StDrain} state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] in_blk_q, in_blk_d;
    logic [127:0] out_blk_q, out_blk_d;
    logic         done_q, done_d;

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
`ifdef AES_GEARBOX_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Low bit of slot k: (3-k)*32 when word 0 is most significant, k*32 otherwise.
    function automatic logic [6:0] slot_lsb(input logic [1:0] k);
        return MSB_FIRST ? {~k, 5'b0} : {k, 5'b0};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StFill;
            cnt_q     <= 2'd0;
            in_blk_q  <= '0;
            out_blk_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_blk_q  <= in_blk_d;
            out_blk_q <= out_blk_d;
            done_q    <= done_d;
        end
    end

    // Ready is a pure function of state, so valid alone qualifies a handshake here.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_blk_d  = in_blk_q;
        out_blk_d = out_blk_q;
        done_d    = 1'b0;
        if (clear) begin
            state_d   = StFill;
            cnt_d     = 2'd0;
            in_blk_d  = '0;
            out_blk_d = '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (bus.pt_valid_i) begin
                        in_blk_d[slot_lsb(cnt_q) +: 32] = swap_bytes(bus.pt_data_i);
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_d = StIssue;
                    end
                end
                StIssue: begin
                    if (bus.blk_ready_i) state_d = StWait;
                end
                StWait: begin
                    if (bus.res_valid_i) begin
                        out_blk_d = bus.res_data_i;
                        state_d   = StDrain;
                    end
                end
                StDrain: begin
                    if (bus.ct_ready_i) begin
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = StFill;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_comb begin
        bus.pt_ready_o  = (state_q == StFill);
        bus.blk_valid_o = (state_q == StIssue);
        bus.blk_data_o  = in_blk_q;
        bus.res_ready_o = (state_q == StWait);
        bus.ct_valid_o  = (state_q == StDrain);
        bus.ct_data_o   = swap_bytes(out_blk_q[slot_lsb(cnt_q) +: 32]);
        bus.word_cnt_o  = cnt_q;
        bus.busy_o      = !((state_q == StFill) && (cnt_q == 2'd0));
        bus.done_o      = done_q;
    end
endmodule

// File: tb/tb_aes_block_gearbox.sv
// Self-checking bench for aes_block_gearbox: directed cases plus randomized blocks and
// backpressure, checked against a word/block reference model.
module tb_aes_block_gearbox;
    localparam bit MSB = 1'b1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;

    aes_block_gearbox_if bus();

    aes_block_gearbox #(.MSB_FIRST(MSB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0]  words [4];
    logic [127:0] res_blk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_GEARBOX_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Reference block: word 0 lands at the top when MSB-first, at the bottom otherwise.
    function automatic logic [127:0] exp_block();
        logic [127:0] b = '0;
        for (int k = 0; k < 4; k++) begin
            if (MSB) b = (b << 32) | {96'b0, sw(words[k])};
            else     b = b | ({96'b0, sw(words[k])} << (32 * k));
        end
        return b;
    endfunction

    function automatic logic [31:0] exp_ct(input int k);
        logic [127:0] t;
        t = MSB ? (res_blk >> (32 * (3 - k))) : (res_blk >> (32 * k));
        return sw(t[31:0]);
    endfunction

    task automatic push_word(input logic [31:0] w);
        bus.pt_valid_i = 1'b1;
        bus.pt_data_i  = w;
        chk1("pt_ready_fill", bus.pt_ready_o, 1'b1);
        chk1("res_ready_fill", bus.res_ready_o, 1'b0);
        @(negedge clk);
        bus.pt_valid_i = 1'b0;
    endtask

    task automatic do_fill(input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.res_valid_i = 1'($urandom_range(0, 1));
                    bus.res_data_i  = {$urandom, $urandom, $urandom, $urandom};
                    @(negedge clk);
                end
            end
            push_word(words[k]);
            if (k < 3) chk32("word_cnt_fill", 32'(bus.word_cnt_o), 32'(k + 1));
        end
        bus.res_valid_i = 1'b0;
        chk1("blk_valid_latency", bus.blk_valid_o, 1'b1);
        chk128("blk_data", bus.blk_data_o, exp_block());
        chk1("pt_ready_issue", bus.pt_ready_o, 1'b0);
        chk1("busy_issue", bus.busy_o, 1'b1);
    endtask

    task automatic do_issue(input int hold);
        bus.blk_ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.pt_valid_i = 1'b1;
            bus.pt_data_i  = $urandom;
            chk1("blk_valid_hold", bus.blk_valid_o, 1'b1);
            chk128("blk_data_hold", bus.blk_data_o, exp_block());
            chk1("pt_ready_hold", bus.pt_ready_o, 1'b0);
            @(negedge clk);
        end
        bus.pt_valid_i  = 1'b0;
        bus.blk_ready_i = 1'b1;
        chk1("blk_valid_accept", bus.blk_valid_o, 1'b1);
        @(negedge clk);
        bus.blk_ready_i = 1'b0;
        chk1("res_ready_wait", bus.res_ready_o, 1'b1);
        chk1("blk_valid_after", bus.blk_valid_o, 1'b0);
    endtask

    task automatic do_result(input int delay);
        bus.res_valid_i = 1'b0;
        repeat (delay) begin
            chk1("res_ready_idle", bus.res_ready_o, 1'b1);
            @(negedge clk);
        end
        bus.res_valid_i = 1'b1;
        bus.res_data_i  = res_blk;
        @(negedge clk);
        bus.res_valid_i = 1'b0;
        bus.res_data_i  = {$urandom, $urandom, $urandom, $urandom};
        chk1("ct_valid_latency", bus.ct_valid_o, 1'b1);
        chk1("res_ready_drain", bus.res_ready_o, 1'b0);
    endtask

    // mode 0: random ct_ready, 1: toggling 1/0, 2: always ready.
    task automatic do_drain(input int mode, input int limit);
        int popped = 0;
        int guard = 0;
        logic r;
        while (popped < limit && guard < 200) begin
            r = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 1) ? (guard % 2 == 0) : 1'b1;
            bus.ct_ready_i = r;
            bus.pt_valid_i = 1'($urandom_range(0, 1));
            bus.pt_data_i  = $urandom;
            chk1("ct_valid", bus.ct_valid_o, 1'b1);
            chk32("ct_data", bus.ct_data_o, exp_ct(popped));
            chk32("word_cnt_drain", 32'(bus.word_cnt_o), 32'(popped));
            @(negedge clk);
            if (r) popped++;
            guard++;
        end
        bus.ct_ready_i = 1'b0;
        bus.pt_valid_i = 1'b0;
        chk32("drain_count", 32'(popped), 32'(limit));
        if (limit == 4) begin
            chk1("done_pulse", bus.done_o, 1'b1);
            chk1("ct_valid_end", bus.ct_valid_o, 1'b0);
            chk32("word_cnt_end", 32'(bus.word_cnt_o), 32'd0);
            chk1("busy_end", bus.busy_o, 1'b0);
            @(negedge clk);
            chk1("done_single", bus.done_o, 1'b0);
        end
    endtask

    task automatic check_idle(input string tag);
        chk1({tag, "_pt_ready"}, bus.pt_ready_o, 1'b1);
        chk1({tag, "_blk_valid"}, bus.blk_valid_o, 1'b0);
        chk1({tag, "_res_ready"}, bus.res_ready_o, 1'b0);
        chk1({tag, "_ct_valid"}, bus.ct_valid_o, 1'b0);
        chk1({tag, "_done"}, bus.done_o, 1'b0);
        chk1({tag, "_busy"}, bus.busy_o, 1'b0);
        chk32({tag, "_word_cnt"}, 32'(bus.word_cnt_o), 32'd0);
        chk128({tag, "_blk_data"}, bus.blk_data_o, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pt_valid_i  = 1'b0;
        bus.pt_data_i   = '0;
        bus.blk_ready_i = 1'b0;
        bus.res_valid_i = 1'b0;
        bus.res_data_i  = '0;
        bus.ct_ready_i  = 1'b0;

        repeat (2) @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Known-answer fill, long issue stall, toggling drain.
        words[0] = 32'h00112233; words[1] = 32'h44556677;
        words[2] = 32'h8899AABB; words[3] = 32'hCCDDEEFF;
        do_fill(1'b0);
        do_issue(10);
        res_blk = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
        do_result(0);
        do_drain(1, 4);

        // Clear coincident with the third plaintext handshake.
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        push_word(words[0]);
        push_word(words[1]);
        bus.pt_valid_i = 1'b1;
        bus.pt_data_i  = words[2];
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        bus.pt_valid_i = 1'b0;
        check_idle("clear");
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        do_fill(1'b0);
        do_issue(0);
        res_blk = {$urandom, $urandom, $urandom, $urandom};
        do_result(1);
        do_drain(2, 4);

        // Randomized blocks with random backpressure on every interface.
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) words[k] = $urandom;
            res_blk = {$urandom, $urandom, $urandom, $urandom};
            do_fill(1'b1);
            do_issue($urandom_range(0, 4));
            do_result($urandom_range(0, 3));
            do_drain(0, 4);
        end

        // Reset mid-drain after two words.
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        res_blk = {$urandom, $urandom, $urandom, $urandom};
        do_fill(1'b0);
        do_issue(1);
        do_result(0);
        do_drain(2, 2);
        reset_n = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk1("no_ct_after_reset", bus.ct_valid_o, 1'b0);
        end
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        res_blk = {$urandom, $urandom, $urandom, $urandom};
        do_fill(1'b1);
        do_issue(2);
        do_result(2);
        do_drain(0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_block_gearbox.md
AES_BLOCK_GEARBOX -- requirements
Module: aes_block_gearbox

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1: 1 = stream word 0 maps to block bits [127:96]; 0 = word 0 maps to bits [31:0].
REQ-002 SHALL have port clk  in  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clear  in  1  synchronous soft clear.
REQ-005 SHALL have ports pt_valid_i  in  1, pt_data_i  in  32 and pt_ready_o  out  1, forming the plaintext word stream from the source streamer.
REQ-006 SHALL have ports blk_valid_o  out  1, blk_data_o  out  128 and blk_ready_i  in  1, forming the assembled block to the cipher core.
REQ-007 SHALL have ports res_valid_i  in  1, res_data_i  in  128 and res_ready_o  out  1, forming the result block from the cipher core.
REQ-008 SHALL have ports ct_valid_o  out  1, ct_data_o  out  32 and ct_ready_i  in  1, forming the ciphertext word stream to the sink streamer.
REQ-009 SHALL have port word_cnt_o  out  2  current word slot index.
REQ-010 SHALL have port busy_o  out  1  high in every state except FILL with word_cnt_o==0.
REQ-011 SHALL have port done_o  out  1  one-cycle pulse per completed block.

Function
REQ-012 SHALL implement the states FILL, ISSUE, WAIT and DRAIN with a 2-bit word counter.
REQ-013 SHALL count a handshake on a stream only on a cycle where its valid and ready are both high.
REQ-014 SHALL, in FILL, drive pt_ready_o=1, write pt_data_i into slot word_cnt on each handshake and increment the counter.
REQ-015 SHALL, on the handshake with word_cnt==3, wrap the counter to 0 and enter ISSUE.
REQ-016 SHALL drive pt_ready_o=0 in every state other than FILL.
REQ-017 SHALL, in ISSUE, drive blk_valid_o=1 and enter WAIT on blk_ready_i.
REQ-018 SHALL hold blk_data_o stable while blk_valid_o=1.
REQ-019 SHALL raise blk_valid_o exactly 1 cycle after the 4th plaintext handshake.
REQ-020 SHALL, in WAIT, drive res_ready_o=1, capture res_data_i into the output register on handshake and enter DRAIN.
REQ-021 SHALL drive res_ready_o=0 outside WAIT.
REQ-022 SHALL, in DRAIN, drive ct_valid_o=1 with ct_data_o = output slot word_cnt, and increment the counter on each handshake.
REQ-023 SHALL raise ct_valid_o 1 cycle after the result handshake.
REQ-024 SHALL hold ct_data_o stable while ct_valid_o=1 and ct_ready_i=0.
REQ-025 SHALL, on the DRAIN handshake with word_cnt==3, wrap the counter to 0, enter FILL and register done_o=1 for exactly the next cycle.
REQ-026 SHALL map slot k to bits [127-32k -: 32] when MSB_FIRST=1 and to bits [32k+31 -: 32] when MSB_FIRST=0, for both input and output blocks.
REQ-027 SHALL, on clear=1, at the next edge return to FILL, set word_cnt to 0, zero both block registers and set done_o to 0.
REQ-028 SHALL give clear priority over any simultaneous handshake; a word or block presented in that cycle is discarded.
REQ-029 SHALL ignore res_valid_i outside WAIT.
REQ-030 SHALL ignore pt_valid_i outside FILL.
REQ-031 SHALL drop no data and duplicate no data under any backpressure pattern.

Reset
REQ-032 SHALL, while reset_n=0, force state FILL, word_cnt_o=0, both block registers to 0, done_o=0, blk_valid_o=0, ct_valid_o=0 and res_ready_o=0, with pt_ready_o=1 as implied by FILL.
REQ-033 SHALL, on reset_n assertion mid-block, discard the partial block, and resume from FILL with no residual output.

Configuration
REQ-034 SHALL, with macro AES_GEARBOX_BYTESWAP_EN defined, byte-reverse each 32-bit word on ingress before storing and on egress before driving ct_data_o.
REQ-035 SHALL, without AES_GEARBOX_BYTESWAP_EN, pass words unmodified.
REQ-036 SHALL keep latency and handshake timing identical with and without AES_GEARBOX_BYTESWAP_EN.

Verification
REQ-037 SHALL cover: MSB_FIRST=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF back-to-back -> blk_data_o=0x00112233_44556677_8899AABB_CCDDEEFF one cycle after the 4th handshake.
REQ-038 SHALL cover: res_data_i=0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A with ct_ready_i toggling 1/0 -> ct words 0x69C4E0D8, 0x6A7B0430, 0xD8CDB780, 0x70B4C55A in order, then one done_o pulse.
REQ-039 SHALL cover: blk_ready_i held 0 for 10 cycles -> blk_valid_o=1 and blk_data_o constant throughout, pt_ready_o=0.
REQ-040 SHALL cover: clear asserted together with the 3rd plaintext handshake -> next cycle word_cnt_o=0, state FILL, and a fresh 4 words produce the correct block.
REQ-041 SHALL cover: AES_GEARBOX_BYTESWAP_EN defined, input word 0x00112233 -> stored word 0x33221100; output slot 0x33221100 -> ct_data_o=0x00112233.
REQ-042 SHALL cover: reset_n pulsed low during DRAIN after 2 words -> all outputs at reset values, no further ct_valid_o until a new block completes.
